// File: rtl/vga_console.sv
// Text console writer: takes character bytes and turns them into bus writes
// into a ROWS x COLS text RAM window. It handles the cursor, newline,
// backspace, carriage return, clear screen and scroll. After every byte it
// publishes the cursor position to two registers just below VIDEO_ADDR+'h1000.

`ifndef VIDEO_ADDR
`define VIDEO_ADDR 32'h0001_0000
`endif

module vga_console #(
    parameter logic [31:0] VIDEO_ADDR = `VIDEO_ADDR,
    parameter int          ROWS       = 32,
    parameter int          COLS       = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    strobe,
    output logic                    rw,
    output logic [31:0]             addr,
    output logic [31:0]             d_out,
    input  logic [31:0]             d_in,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    busy
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = $clog2(ROWS * COLS + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [IDX_W-1:0] SCR_LAST = IDX_W'((ROWS - 1) * COLS - 1);
    localparam logic [IDX_W-1:0] FIL_LAST = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(ROWS * COLS - 1);

    // Cursor registers sit just below the 4 KiB boundary above the text RAM.
    localparam logic [31:0] CURX_ADDR = VIDEO_ADDR + 32'h0000_1000 - 32'd2;
    localparam logic [31:0] CURY_ADDR = VIDEO_ADDR + 32'h0000_1000 - 32'd3;
    localparam logic [31:0] LAST_ROW_ADDR = VIDEO_ADDR + 32'((ROWS - 1) * COLS);

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCR_RD,
        SCR_WR,
        FILL,
        CLR,
        CURX,
        CURY
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Only the low byte of read data carries a character.
    logic unused_d_in_hi;
    assign unused_d_in_hi = ^d_in[31:8];

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign cur_row  = row_q;
    assign cur_col  = col_q;

    // State, cursor, latched character and sweep index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, cursor arithmetic and bus drive for every state.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        idx_d   = idx_q;
        strobe  = 1'b0;
        rw      = 1'b0;
        addr    = 32'h0;
        d_out   = 32'h0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    case (in_data)
                        8'h08: begin
                            if (col_q != '0) col_d = col_q - COL_W'(1);
                            state_d = CURX;
                        end
                        8'h0A: begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                idx_d   = '0;
                                state_d = SCR_RD;
                            end else begin
                                row_d   = row_q + ROW_W'(1);
                                state_d = CURX;
                            end
                        end
                        8'h0C: begin
                            idx_d   = '0;
                            state_d = CLR;
                        end
                        8'h0D: begin
                            col_d   = '0;
                            state_d = CURX;
                        end
                        default: state_d = PUT;
                    endcase
                end
            end
            PUT: begin
                strobe = 1'b1;
                rw     = 1'b1;
                addr   = VIDEO_ADDR + 32'(row_q) * 32'(COLS) + 32'(col_q);
                d_out  = {24'h0, data_q};
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        idx_d   = '0;
                        state_d = SCR_RD;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = CURX;
                    end
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = CURX;
                end
            end
            SCR_RD: begin
                strobe  = 1'b1;
                addr    = VIDEO_ADDR + 32'(COLS) + 32'(idx_q);
                state_d = SCR_WR;
            end
            SCR_WR: begin
                strobe = 1'b1;
                rw     = 1'b1;
                addr   = VIDEO_ADDR + 32'(idx_q);
                d_out  = {24'h0, d_in[7:0]};
                if (idx_q == SCR_LAST) begin
                    idx_d   = '0;
                    state_d = FILL;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCR_RD;
                end
            end
            FILL: begin
                strobe = 1'b1;
                rw     = 1'b1;
                addr   = LAST_ROW_ADDR + 32'(idx_q);
                d_out  = 32'h20;
                if (idx_q == FIL_LAST) state_d = CURX;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            CLR: begin
                strobe = 1'b1;
                rw     = 1'b1;
                addr   = VIDEO_ADDR + 32'(idx_q);
                d_out  = 32'h20;
                if (idx_q == CLR_LAST) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = CURX;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            CURX: begin
                strobe  = 1'b1;
                rw      = 1'b1;
                addr    = CURX_ADDR;
                d_out   = 32'(col_q) + 32'd1;
                state_d = CURY;
            end
            CURY: begin
                strobe  = 1'b1;
                rw      = 1'b1;
                addr    = CURY_ADDR;
                d_out   = 32'(row_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_console.sv
// Directed bench for vga_console: a byte-wide text RAM model answers the
// bus, and each scenario task drives bytes and checks cursor, bus writes,
// RAM contents and busy durations against hand-computed values.

module tb_vga_console;

    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam int ROWS = 32;
    localparam int COLS = 64;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        strobe;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] d_out;
    logic [31:0] d_in;
    logic [4:0]  cur_row;
    logic [5:0]  cur_col;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ram [0:2047];
    logic [31:0] mon_off;
    int          cell_writes = 0;
    logic [31:0] last_cell_addr = 32'h0;
    logic [7:0]  last_cell_data = 8'h0;
    logic [7:0]  curx_data = 8'h0;
    logic [7:0]  cury_data = 8'h0;
    int          bus_viol = 0;
    int          bad_addr = 0;
    int          preload_req = 0;

    vga_console #(.VIDEO_ADDR(BASE), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .strobe   (strobe),
        .rw       (rw),
        .addr     (addr),
        .d_out    (d_out),
        .d_in     (d_in),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text RAM and cursor register model; read data returns the cycle after the strobe.
    always @(posedge clk) begin
        d_in <= 32'h0;
        if (preload_req == 1) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 8'(i / 64);
        end else if (preload_req == 2) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 8'h55;
        end
        if (strobe) begin
            mon_off = addr - BASE;
            if (d_out[31:8] != 24'h0) bus_viol <= bus_viol + 1;
            if (rw) begin
                if (mon_off < 32'd2048) begin
                    ram[mon_off[10:0]] <= d_out[7:0];
                    cell_writes        <= cell_writes + 1;
                    last_cell_addr     <= addr;
                    last_cell_data     <= d_out[7:0];
                end else if (mon_off == 32'hFFE) begin
                    curx_data <= d_out[7:0];
                end else if (mon_off == 32'hFFD) begin
                    cury_data <= d_out[7:0];
                end else begin
                    bad_addr <= bad_addr + 1;
                end
            end else if (mon_off < 32'd2048) begin
                d_in <= {24'h0, ram[mon_off[10:0]]};
            end else begin
                bad_addr <= bad_addr + 1;
            end
        end else if (rw || addr != 32'h0 || d_out != 32'h0) begin
            bus_viol <= bus_viol + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit wait_done, output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
        if (wait_done) begin
            @(negedge clk);
            while (busy && busy_cycles < 10000) begin
                busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic preload(input int mode);
        @(negedge clk);
        preload_req = mode;
        @(negedge clk);
        preload_req = 0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({strobe, rw, busy} !== 3'b000 || addr !== 32'h0 || d_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: strobe=%0b rw=%0b busy=%0b addr=%h d_out=%h required all 0",
                     strobe, rw, busy, addr, d_out);
        end
        checks++;
        if (cur_row !== 5'd0 || cur_col !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_cursor: (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_print();
        int bc;
        send_byte(8'h41, 1'b1, bc);
        checks++;
        if (last_cell_addr !== BASE || last_cell_data !== 8'h41) begin
            errors++;
            $display("[TB] FAIL print_write: addr=%h data=%h required addr=%h data=41",
                     last_cell_addr, last_cell_data, BASE);
        end
        checks++;
        if (curx_data !== 8'd2 || cury_data !== 8'd0) begin
            errors++;
            $display("[TB] FAIL print_curreg: curx=%0d cury=%0d required 2 0", curx_data, cury_data);
        end
        checks++;
        if (cur_row !== 5'd0 || cur_col !== 6'd1) begin
            errors++;
            $display("[TB] FAIL print_cursor: (%0d,%0d) required (0,1)", cur_row, cur_col);
        end
        checks++;
        if (bc !== 3) begin
            errors++;
            $display("[TB] FAIL print_busy: cycles=%0d required 3", bc);
        end
    endtask

    task automatic test_wrap();
        int bc;
        send_byte(8'h0D, 1'b1, bc);
        for (int i = 0; i < 63; i++) send_byte(8'h78, 1'b1, bc);
        checks++;
        if (cur_row !== 5'd0 || cur_col !== 6'd63) begin
            errors++;
            $display("[TB] FAIL wrap_setup: (%0d,%0d) required (0,63)", cur_row, cur_col);
        end
        send_byte(8'h5A, 1'b1, bc);
        checks++;
        if (last_cell_addr !== BASE + 32'd63 || last_cell_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL wrap_write: addr=%h data=%h required addr=%h data=5a",
                     last_cell_addr, last_cell_data, BASE + 32'd63);
        end
        checks++;
        if (cur_row !== 5'd1 || cur_col !== 6'd0 || curx_data !== 8'd1 || cury_data !== 8'd1) begin
            errors++;
            $display("[TB] FAIL wrap_cursor: (%0d,%0d) curx=%0d cury=%0d required (1,0) 1 1",
                     cur_row, cur_col, curx_data, cury_data);
        end
    endtask

    task automatic test_control();
        int bc;
        int cw0;
        send_byte(8'h0A, 1'b1, bc);
        send_byte(8'h0A, 1'b1, bc);
        cw0 = cell_writes;
        send_byte(8'h08, 1'b1, bc);
        checks++;
        if (cur_row !== 5'd3 || cur_col !== 6'd0 || bc !== 2 || cell_writes !== cw0) begin
            errors++;
            $display("[TB] FAIL bs_at_col0: (%0d,%0d) busy=%0d writes=%0d required (3,0) 2 0",
                     cur_row, cur_col, bc, cell_writes - cw0);
        end
        for (int i = 0; i < 4; i++) send_byte(8'h61, 1'b1, bc);
        cw0 = cell_writes;
        send_byte(8'h08, 1'b1, bc);
        checks++;
        if (cur_col !== 6'd3 || cell_writes !== cw0 || curx_data !== 8'd4) begin
            errors++;
            $display("[TB] FAIL bs_step: col=%0d writes=%0d curx=%0d required 3 0 4",
                     cur_col, cell_writes - cw0, curx_data);
        end
        send_byte(8'h61, 1'b1, bc);
        send_byte(8'h0D, 1'b1, bc);
        checks++;
        if (cur_row !== 5'd3 || cur_col !== 6'd0 || bc !== 2) begin
            errors++;
            $display("[TB] FAIL cr: (%0d,%0d) busy=%0d required (3,0) 2", cur_row, cur_col, bc);
        end
    endtask

    task automatic test_scroll();
        int bc;
        int bad;
        logic [7:0] exp;
        for (int i = 0; i < 28; i++) send_byte(8'h0A, 1'b1, bc);
        for (int i = 0; i < 5; i++) send_byte(8'h62, 1'b1, bc);
        checks++;
        if (cur_row !== 5'd31 || cur_col !== 6'd5) begin
            errors++;
            $display("[TB] FAIL scroll_setup: (%0d,%0d) required (31,5)", cur_row, cur_col);
        end
        preload(1);
        send_byte(8'h0A, 1'b1, bc);
        checks++;
        if (bc !== 2 * 31 * 64 + 64 + 2) begin
            errors++;
            $display("[TB] FAIL scroll_busy: cycles=%0d required %0d", bc, 2 * 31 * 64 + 64 + 2);
        end
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            exp = (i < 31 * 64) ? 8'(i / 64 + 1) : 8'h20;
            if (ram[i] !== exp) bad++;
        end
        checks++;
        if (bad !== 0 || ram[0] !== 8'd1 || ram[1983] !== 8'd31 || ram[1984] !== 8'h20) begin
            errors++;
            $display("[TB] FAIL scroll_ram: bad_cells=%0d ram0=%h ram1983=%h ram1984=%h required 0 01 1f 20",
                     bad, ram[0], ram[1983], ram[1984]);
        end
        checks++;
        if (cur_row !== 5'd31 || cur_col !== 6'd0 || curx_data !== 8'd1 || cury_data !== 8'd31) begin
            errors++;
            $display("[TB] FAIL scroll_cursor: (%0d,%0d) curx=%0d cury=%0d required (31,0) 1 31",
                     cur_row, cur_col, curx_data, cury_data);
        end
    endtask

    task automatic test_clear();
        int bc;
        int cw0;
        int bad;
        preload(2);
        cw0 = cell_writes;
        send_byte(8'h0C, 1'b1, bc);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (ram[i] !== 8'h20) bad++;
        checks++;
        if (bc !== 2050 || cell_writes - cw0 !== 2048 || bad !== 0) begin
            errors++;
            $display("[TB] FAIL clear: busy=%0d writes=%0d bad_cells=%0d required 2050 2048 0",
                     bc, cell_writes - cw0, bad);
        end
        checks++;
        if (last_cell_addr !== BASE + 32'd2047 || cur_row !== 5'd0 || cur_col !== 6'd0
            || curx_data !== 8'd1 || cury_data !== 8'd0) begin
            errors++;
            $display("[TB] FAIL clear_cursor: last=%h (%0d,%0d) curx=%0d cury=%0d required %h (0,0) 1 0",
                     last_cell_addr, cur_row, cur_col, curx_data, cury_data, BASE + 32'd2047);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int bc;
        for (int i = 0; i < 31; i++) send_byte(8'h0A, 1'b1, bc);
        send_byte(8'h0A, 1'b0, bc);
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midscroll_active: busy=%0b strobe=%0b required 1 1", busy, strobe);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (strobe !== 1'b0 || busy !== 1'b0 || addr !== 32'h0 || cur_row !== 5'd0 || cur_col !== 6'd0) begin
            errors++;
            $display("[TB] FAIL midscroll_reset: strobe=%0b busy=%0b addr=%h (%0d,%0d) required 0 0 0 (0,0)",
                     strobe, busy, addr, cur_row, cur_col);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midscroll_ready: in_ready=%0b required 1", in_ready);
        end
        send_byte(8'h42, 1'b1, bc);
        checks++;
        if (last_cell_addr !== BASE || last_cell_data !== 8'h42 || cur_col !== 6'd1) begin
            errors++;
            $display("[TB] FAIL after_reset_put: addr=%h data=%h col=%0d required %h 42 1",
                     last_cell_addr, last_cell_data, cur_col, BASE);
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (bus_viol !== 0 || bad_addr !== 0) begin
            errors++;
            $display("[TB] FAIL bus_rules: idle_bus_violations=%0d stray_addresses=%0d required 0 0",
                     bus_viol, bad_addr);
        end
    endtask

    initial begin
        test_reset();
        test_print();
        test_wrap();
        test_control();
        test_scroll();
        test_clear();
        test_reset_mid_scroll();
        test_bus_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
